// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches words over a readM/inputReady handshake,
// holds them in the IR for the decoder, and owns the PC and retire counter.
module instr_fetch_unit #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 readM,
  output logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  output logic [WORD_SIZE-1:0] instruction,
  output logic                 instr_valid,
  input  logic                 advance,
  input  logic                 jump,
  input  logic                 branch_taken,
  output logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] num_inst
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] ir_q, ir_d;
  logic [WORD_SIZE-1:0] num_q, num_d;
  logic [WORD_SIZE-1:0] next_pc;
  logic [WORD_SIZE-1:0] branch_off;

  assign branch_off = {{(WORD_SIZE-8){ir_q[7]}}, ir_q[7:0]};

  // Jump keeps the PC's top nibble (page) and replaces the low 12 bits.
  always_comb begin
    if (jump)              next_pc = {pc_q[WORD_SIZE-1:12], ir_q[11:0]};
    else if (branch_taken) next_pc = pc_q + WORD_SIZE'(1) + branch_off;
    else                   next_pc = pc_q + WORD_SIZE'(1);
  end

  always_comb begin
    // NOTE: every target gets its hold value first so no path leaves it unassigned (no latch).
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    num_d   = num_q;
    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (inputReady) begin
          ir_d    = data;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (advance) begin
          pc_d    = next_pc;
          num_d   = num_q + WORD_SIZE'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      num_q   <= num_d;
    end
  end

  // Handshake outputs decode the registered state, so reset clears them at once.
  assign readM       = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_HOLD);
  assign address     = pc_q;
  assign pc          = pc_q;
  assign instruction = ir_q;
  assign num_inst    = num_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: handshake timing, PC
// update rules, wrap-around, ignored inputs and asynchronous reset.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        readM;
  logic [15:0] address;
  logic [15:0] data;
  logic        inputReady;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        advance;
  logic        jump;
  logic        branch_taken;
  logic [15:0] pc;
  logic [15:0] num_inst;

  int checks   = 0;
  int failures = 0;

  instr_fetch_unit #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .readM        (readM),
    .address      (address),
    .data         (data),
    .inputReady   (inputReady),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .advance      (advance),
    .jump         (jump),
    .branch_taken (branch_taken),
    .pc           (pc),
    .num_inst     (num_inst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Entered at a negedge with the DUT in fetch at exp_pc; leaves it holding word d.
  task automatic fetch(input string tag, input logic [15:0] d, input int latency,
                       input logic [15:0] exp_pc);
    for (int i = 0; i < latency; i++) begin
      inputReady = 1'b0;
      data       = 16'hDEAD;
      @(negedge clk);
      check({tag, " wait readM"},   readM,       1);
      check({tag, " wait address"}, address,     exp_pc);
      check({tag, " wait valid"},   instr_valid, 0);
    end
    inputReady = 1'b1;
    data       = d;
    @(negedge clk);
    inputReady = 1'b0;
    data       = 16'h0000;
    check({tag, " ir"},    instruction, d);
    check({tag, " valid"}, instr_valid, 1);
    check({tag, " readM"}, readM,       0);
    check({tag, " pc"},    pc,          exp_pc);
  endtask

  task automatic retire(input string tag, input logic j, input logic b,
                        input logic [15:0] exp_pc, input logic [15:0] exp_num);
    advance      = 1'b1;
    jump         = j;
    branch_taken = b;
    @(negedge clk);
    advance      = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
    check({tag, " next pc"}, pc,          exp_pc);
    check({tag, " num"},     num_inst,    exp_num);
    check({tag, " valid"},   instr_valid, 0);
    check({tag, " readM"},   readM,       1);
  endtask

  initial begin
    reset_n      = 1'b0;
    data         = 16'h0000;
    inputReady   = 1'b0;
    advance      = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
    #1;
    check("reset readM", readM,       0);
    check("reset pc",    pc,          16'h0000);
    check("reset ir",    instruction, 16'h0000);
    check("reset valid", instr_valid, 0);
    check("reset num",   num_inst,    16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("first readM",   readM,   1);
    check("first address", address, 16'h0000);

    fetch ("t1", 16'h4105, 0, 16'h0000);
    retire("t1", 1'b0, 1'b0, 16'h0001, 16'd1);
    fetch ("t2", 16'h000E, 4, 16'h0001);
    retire("t2 br+14", 1'b0, 1'b1, 16'h0010, 16'd2);
    fetch ("t3", 16'h1234, 1, 16'h0010);
    retire("t3 seq", 1'b0, 1'b0, 16'h0011, 16'd3);
    fetch ("t3b", 16'h000E, 0, 16'h0011);
    retire("t3b br", 1'b0, 1'b1, 16'h0020, 16'd4);
    fetch ("t3c", 16'h00FE, 2, 16'h0020);
    retire("t3c br-2", 1'b0, 1'b1, 16'h001F, 16'd5);
    fetch ("t4", 16'h9ABC, 0, 16'h001F);
    retire("t4 jmp wins", 1'b1, 1'b1, 16'h0ABC, 16'd6);
    fetch ("t4b", 16'h7000, 0, 16'h0ABC);
    retire("t4b jmp", 1'b1, 1'b0, 16'h0000, 16'd7);
    fetch ("t5", 16'h00FE, 0, 16'h0000);
    retire("t5 br under", 1'b0, 1'b1, 16'hFFFF, 16'd8);
    fetch ("t5b", 16'h0000, 0, 16'hFFFF);
    retire("t5b wrap", 1'b0, 1'b0, 16'h0000, 16'd9);

    // Advance/jump during fetch must do nothing; inputReady during hold must not reload IR.
    advance = 1'b1;
    jump    = 1'b1;
    fetch ("ign", 16'h5555, 1, 16'h0000);
    advance = 1'b0;
    jump    = 1'b0;
    check("ign num", num_inst, 16'd9);
    inputReady = 1'b1;
    data       = 16'hAAAA;
    @(negedge clk);
    inputReady = 1'b0;
    check("ign hold ir",    instruction, 16'h5555);
    check("ign hold valid", instr_valid, 1);
    check("ign hold pc",    pc,          16'h0000);
    retire("ign", 1'b0, 1'b0, 16'h0001, 16'd10);

    fetch ("t7", 16'h00FD, 0, 16'h0001);
    retire("t7 br-3", 1'b0, 1'b1, 16'hFFFF, 16'd11);
    fetch ("t8", 16'h0123, 0, 16'hFFFF);
    retire("t8 jmp page", 1'b1, 1'b0, 16'hF123, 16'd12);
    fetch ("t9", 16'h0080, 0, 16'hF123);
    retire("t9 br-128", 1'b0, 1'b1, 16'hF0A4, 16'd13);

    // Asynchronous reset in the middle of a pending fetch.
    @(negedge clk);
    check("t6 pre readM", readM, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6 async readM", readM,       0);
    check("t6 async pc",    pc,          16'h0000);
    check("t6 async num",   num_inst,    16'h0000);
    check("t6 async ir",    instruction, 16'h0000);
    inputReady = 1'b1;
    data       = 16'hBEEF;
    @(negedge clk);
    check("t6 in reset ir", instruction, 16'h0000);
    reset_n = 1'b1;
    @(negedge clk);
    check("t6 stale ir",    instruction, 16'h0000);
    check("t6 stale valid", instr_valid, 0);
    check("t6 refetch",     readM,       1);
    inputReady = 1'b0;
    data       = 16'h0000;
    fetch ("t6 after", 16'h2468, 0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
